// File: rtl/uart_rx_mem_loader_if.sv
// Byte-stream input, memory write port and status of the UART-to-memory loader.
// The loader uses the slave modport; the byte source/memory side uses master.
interface uart_rx_mem_loader_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic                  enable;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  rx_data_valid;
  logic [7:0]            rx_p_data;
  logic                  rx_par_err;
  logic                  rx_stp_error;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [1:0]            err_code;
  logic [7:0]            words_written;

  modport slave (
    input  enable, start_addr, rx_data_valid, rx_p_data, rx_par_err, rx_stp_error,
    output mem_wr_en, mem_addr, mem_data_in, busy, done, err, err_code, words_written
  );
  modport master (
    output enable, start_addr, rx_data_valid, rx_p_data, rx_par_err, rx_stp_error,
    input  mem_wr_en, mem_addr, mem_data_in, busy, done, err, err_code, words_written
  );
endinterface

// File: rtl/uart_rx_mem_loader.sv
// Assembles SYNC/LEN/payload/CHK packets from a UART byte stream into
// little-endian words written to consecutive (wrapping) memory addresses.
module uart_rx_mem_loader #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         MEM_DEPTH      = 64,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_rx_mem_loader_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH);
  localparam int BPW        = DATA_WIDTH / 8;
  localparam int BIDX_W     = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int TMO_W      = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_CHK} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [BIDX_W-1:0]     r_bidx;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [7:0]            r_chk;
  logic [TMO_W-1:0]      r_tmo;
  logic                  r_wr_en;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_done;
  logic                  r_err;
  logic [1:0]            r_err_code;
  logic [7:0]            r_words;

  logic                  w_acc;
  logic                  w_lerr;
  logic                  w_word_end;
  logic                  w_tmo;
  logic [DATA_WIDTH-1:0] w_asm_nxt;

  assign w_acc      = bus.rx_data_valid & ~bus.rx_par_err & ~bus.rx_stp_error;
  assign w_lerr     = bus.rx_data_valid & (bus.rx_par_err | bus.rx_stp_error);
  assign w_word_end = (r_bidx == BIDX_W'(BPW - 1));
  assign w_tmo      = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
  // New byte enters at the top; after BPW bytes the first one sits in [7:0].
  assign w_asm_nxt  = (r_asm >> 8) | (DATA_WIDTH'(bus.rx_p_data) << (DATA_WIDTH - 8));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_len      <= '0;
      r_bidx     <= '0;
      r_asm      <= '0;
      r_chk      <= '0;
      r_tmo      <= '0;
      r_wr_en    <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
      r_words    <= '0;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == S_IDLE || bus.rx_data_valid) r_tmo <= '0;
      else                                        r_tmo <= r_tmo + TMO_W'(1);

      if (r_state == S_IDLE) begin
        if (bus.enable && w_acc && bus.rx_p_data == SYNC_BYTE) begin
          r_addr  <= bus.start_addr;
          r_words <= '0;
          r_chk   <= '0;
          r_state <= S_LEN;
        end
      end else if (w_lerr) begin
        r_err      <= 1'b1;
        r_err_code <= 2'b01;
        r_state    <= S_IDLE;
      end else if (w_acc) begin
        case (r_state)
          S_LEN: begin
            r_len   <= bus.rx_p_data;
            r_bidx  <= '0;
            r_asm   <= '0;
            r_state <= (bus.rx_p_data == 8'd0) ? S_CHK : S_DATA;
          end
          S_DATA: begin
            r_asm <= w_asm_nxt;
            r_chk <= r_chk ^ bus.rx_p_data;
            if (w_word_end) begin
              r_bidx     <= '0;
              r_wr_en    <= 1'b1;
              r_mem_data <= w_asm_nxt;
              r_mem_addr <= r_addr;
              r_addr     <= (r_addr == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);
              r_words    <= r_words + 8'd1;
              if (r_words + 8'd1 == r_len) r_state <= S_CHK;
            end else begin
              r_bidx <= r_bidx + BIDX_W'(1);
            end
          end
          default: begin
            if (bus.rx_p_data == r_chk) begin
              r_done <= 1'b1;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= 2'b11;
            end
            r_state <= S_IDLE;
          end
        endcase
      end else if (w_tmo) begin
        // No byte this cycle and the idle budget is used up.
        r_err      <= 1'b1;
        r_err_code <= 2'b10;
        r_state    <= S_IDLE;
      end
    end
  end

  assign bus.mem_wr_en     = r_wr_en;
  assign bus.mem_addr      = r_mem_addr;
  assign bus.mem_data_in   = r_mem_data;
  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = r_done;
  assign bus.err           = r_err;
  assign bus.err_code      = r_err_code;
  assign bus.words_written = r_words;
endmodule

// File: tb/tb_uart_rx_mem_loader.sv
// Random and directed packets against a list-walking packet model:
// expected writes, done/err outcome, err_code and words_written.
module tb_uart_rx_mem_loader;
  localparam int DW = 32, DEPTH = 64, AW = 6, BPW = 4, TMO = 1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_mem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  uart_rx_mem_loader #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_chk = 0, n_fail = 0;
  int n_done = 0, n_err = 0, n_overlap = 0;
  int exp_code = 0;
  bit drop_en = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];
  logic [7:0]    q_b[$];
  logic [1:0]    q_e[$];
  int            q_g[$];

  task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_wr_en) begin
      wa_q.push_back(bus.mem_addr);
      wd_q.push_back(bus.mem_data_in);
    end
    if (bus.done) n_done++;
    if (bus.err) n_err++;
    if (int'(bus.mem_wr_en) + int'(bus.done) + int'(bus.err) > 1) n_overlap++;
  end

  task automatic send_byte(input logic [7:0] b, input logic pe, input logic se);
    @(negedge clk);
    bus.rx_data_valid = 1'b1; bus.rx_p_data = b; bus.rx_par_err = pe; bus.rx_stp_error = se;
    @(negedge clk);
    bus.rx_data_valid = 1'b0; bus.rx_par_err = 1'b0; bus.rx_stp_error = 1'b0;
  endtask

  task automatic add(input logic [7:0] b);
    q_b.push_back(b); q_e.push_back(2'b00); q_g.push_back(0);
  endtask

  task automatic build(input int len, input bit bad_chk);
    logic [7:0] x, b, l8;
    x = 8'h00; l8 = 8'(len);
    q_b.delete(); q_e.delete(); q_g.delete();
    add(8'hA5);
    add(l8);
    for (int i = 0; i < len * BPW; i++) begin
      b = 8'($urandom);
      x = x ^ b;
      add(b);
    end
    if (bad_chk) add(x ^ 8'($urandom_range(1, 255)));
    else         add(x);
  endtask

  task automatic check_idle_zero(input string tag);
    tb_check({tag, "_wr"},   bus.mem_wr_en, 0);
    tb_check({tag, "_addr"}, bus.mem_addr, 0);
    tb_check({tag, "_data"}, bus.mem_data_in, 0);
    tb_check({tag, "_busy"}, bus.busy, 0);
    tb_check({tag, "_done"}, bus.done, 0);
    tb_check({tag, "_err"},  bus.err, 0);
    tb_check({tag, "_code"}, bus.err_code, 0);
    tb_check({tag, "_ww"},   bus.words_written, 0);
  endtask

  // Model walks the byte list by packet rules, then the list is replayed to the DUT.
  task automatic run_pkt(input logic [AW-1:0] sa);
    int len, outcome, stop_at, nw, p, bw, bd, be, nchk;
    logic [7:0] x;
    logic [DW-1:0] w;
    logic [AW-1:0] ea[$];
    logic [DW-1:0] ed[$];
    len = 0; outcome = -1; stop_at = 0; nw = 0; x = 8'h00; w = '0;
    for (int i = 1; i < q_b.size() && outcome < 0; i++) begin
      if (q_g[i] + 1 >= TMO) begin outcome = 2; stop_at = i; end
      else if (q_e[i] != 2'b00) begin outcome = 1; stop_at = i; end
      else if (i == 1) len = int'(q_b[1]);
      else if (i - 2 < len * BPW) begin
        p = i - 2;
        x = x ^ q_b[i];
        w[8*(p%BPW) +: 8] = q_b[i];
        if (p % BPW == BPW - 1) begin
          ea.push_back(AW'((int'(sa) + p / BPW) % DEPTH));
          ed.push_back(w);
          nw++;
        end
      end else begin
        outcome = (q_b[i] == x) ? 0 : 3;
        stop_at = i;
      end
    end

    bus.start_addr = sa;
    bus.enable = 1'b1;
    bw = wa_q.size(); bd = n_done; be = n_err;
    for (int i = 0; i < q_b.size(); i++) begin
      if (i == stop_at && outcome == 2) begin
        repeat (TMO - 1) @(negedge clk);
        tb_check("tmo_early", bus.err, 0);
        @(negedge clk);
        tb_check("tmo_edge", bus.err, 1);
        repeat (2) @(negedge clk);
        break;
      end
      repeat (q_g[i]) @(negedge clk);
      send_byte(q_b[i], q_e[i][0], q_e[i][1]);
      if (i == 0) begin
        tb_check("busy_hi", bus.busy, 1);
        if (drop_en) bus.enable = 1'b0;
      end
      if (i == stop_at) break;
    end
    repeat (3) @(negedge clk);

    if (outcome > 0) exp_code = outcome;
    tb_check("wr_cnt", wa_q.size() - bw, ea.size());
    nchk = (wa_q.size() - bw < ea.size()) ? wa_q.size() - bw : ea.size();
    for (int k = 0; k < nchk; k++) begin
      tb_check("wr_addr", wa_q[bw+k], ea[k]);
      tb_check("wr_data", wd_q[bw+k], ed[k]);
    end
    tb_check("done_cnt", n_done - bd, (outcome == 0) ? 1 : 0);
    tb_check("err_cnt", n_err - be, (outcome > 0) ? 1 : 0);
    tb_check("err_code", bus.err_code, exp_code);
    tb_check("words_wr", bus.words_written, nw);
    tb_check("busy_lo", bus.busy, 0);
    tb_check("overlap", n_overlap, 0);
  endtask

  initial begin
    int bw, idx;
    logic [7:0] jb;
    bus.enable = 1'b0; bus.start_addr = '0; bus.rx_data_valid = 1'b0;
    bus.rx_p_data = 8'h00; bus.rx_par_err = 1'b0; bus.rx_stp_error = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_zero("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic two-word load at 5, then wrap from 63.
    build(2, 0); run_pkt(6'd5);
    build(2, 0); run_pkt(6'd63);

    // Bad checksum: word is still written.
    build(1, 0);
    q_b[2] = 8'h01; q_b[3] = 8'h02; q_b[4] = 8'h03; q_b[5] = 8'h04; q_b[6] = 8'h00;
    run_pkt(6'd20);

    // Stop-bit error on third payload byte.
    build(1, 0); q_e[4] = 2'b10; run_pkt(6'd7);
    // Parity error on LEN.
    build(3, 0); q_e[1] = 2'b01; run_pkt(6'd9);

    // Timeout after LEN, and a byte one cycle before expiry.
    build(1, 0); q_g[2] = TMO - 1; run_pkt(6'd30);
    build(1, 0); q_g[2] = TMO - 2; run_pkt(6'd31);
    build(0, 0); run_pkt(6'd2);

    // enable=0 in IDLE: sync and following bytes ignored.
    bus.enable = 1'b0;
    bw = wa_q.size();
    build(1, 0);
    for (int i = 0; i < q_b.size(); i++) begin
      send_byte(q_b[i], 1'b0, 1'b0);
      tb_check("en0_busy", bus.busy, 0);
    end
    tb_check("en0_wr", wa_q.size() - bw, 0);
    // Errored sync byte in IDLE is ignored too.
    bus.enable = 1'b1;
    send_byte(8'hA5, 1'b1, 1'b0);
    tb_check("errsync_busy", bus.busy, 0);

    // enable dropped mid-packet has no effect.
    drop_en = 1; build(2, 0); run_pkt(6'd40); drop_en = 0;

    // Reset mid-DATA, then a clean packet.
    build(3, 0);
    bus.start_addr = 6'd50;
    for (int i = 0; i < 7; i++) send_byte(q_b[i], 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    bw = wa_q.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tb_check("rst_nowr", wa_q.size() - bw, 0);
    exp_code = 0;
    build(2, 0); run_pkt(6'd10);

    // Random packets with junk, errors, gaps and timeouts.
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) begin
        jb = 8'($urandom);
        if (jb == 8'hA5) jb = 8'h00;
        send_byte(jb, 1'($urandom_range(0, 1)), 1'b0);
      end
      build($urandom_range(0, 5), ($urandom_range(0, 3) == 0));
      for (int i = 1; i < q_b.size(); i++) q_g[i] = $urandom_range(0, 3);
      idx = $urandom_range(1, q_b.size() - 1);
      case ($urandom_range(0, 9))
        0, 1: q_e[idx] = 2'($urandom_range(1, 3));
        2:    q_g[idx] = TMO - 1;
        3:    q_g[idx] = TMO - 2;
        default: ;
      endcase
      drop_en = ($urandom_range(0, 3) == 0);
      run_pkt(6'($urandom_range(0, DEPTH - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
